// File: rtl/ads5404_snap_pkg.sv
// Shared types and sizing for the ADS5404 snapshot capture block.
// ADS5404_SNAP_OVR_EN adds the four overrange flags to every stored word.
package ads5404_snap_pkg;

    localparam int unsigned NBITS_DEF  = 12;
    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DLY_W      = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_CAPTURE,
        S_DONE
    } state_t;

    // Stored word width for a given sample width.
    function automatic int unsigned word_w(input int unsigned nbits);
`ifdef ADS5404_SNAP_OVR_EN
        return 4 * nbits + 4;
`else
        return 4 * nbits;
`endif
    endfunction

endpackage

// File: rtl/ads5404_snap_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port, read-first.
module ads5404_snap_ram #(
    parameter int unsigned W      = 48,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [W-1:0] mem [DEPTH];

    // Read samples the array before this edge's write lands, so a colliding read sees old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ads5404_snapshot.sv
// Triggered snapshot capture of de-interleaved ADS5404 samples into a 2^ADDR_W word buffer.
// Define ADS5404_SNAP_OVR_EN to store {ovrb_1, ovrb_0, ovra_1, ovra_0} above the samples.
module ads5404_snapshot
    import ads5404_snap_pkg::*;
#(
    parameter int unsigned  NBITS  = NBITS_DEF,
    parameter int unsigned  ADDR_W = ADDR_W_DEF,
    localparam int unsigned W      = word_w(NBITS)
) (
    input  logic              adc_clk,
    input  logic              user_rst_n,
    input  logic [NBITS-1:0]  da_0,
    input  logic [NBITS-1:0]  da_1,
    input  logic [NBITS-1:0]  db_0,
    input  logic [NBITS-1:0]  db_1,
    input  logic              syncout_0,
    input  logic              syncout_1,
    input  logic              ovra_0,
    input  logic              ovra_1,
    input  logic              ovrb_0,
    input  logic              ovrb_1,
    input  logic              arm,
    input  logic              trig_sel,
    input  logic              sw_trig,
    input  logic [DLY_W-1:0]  trig_delay,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [W-1:0]      rd_data,
    output logic              armed,
    output logic              capturing,
    output logic              done,
    output logic              trig_lane
);

    state_t            state, state_n;
    logic [DLY_W-1:0]  dly_cnt, dly_n;
    logic [ADDR_W-1:0] waddr, waddr_n;
    logic              lane_n;
    logic              we_c;
    logic              arm_q;
    logic              sync1_q;
    logic              rd_ok;
    logic [W-1:0]      word_c;
    logic [W-1:0]      word_q;
    logic [W-1:0]      ram_q;

`ifdef ADS5404_SNAP_OVR_EN
    assign word_c = {ovrb_1, ovrb_0, ovra_1, ovra_0, db_1, db_0, da_1, da_0};
`else
    logic unused_ovr;
    assign word_c     = {db_1, db_0, da_1, da_0};
    assign unused_ovr = ^{ovrb_1, ovrb_0, ovra_1, ovra_0};
`endif

    // Lane 0 is preceded in time by lane 1 of the previous cycle.
    logic arm_rise, edge0, edge1, sync_trig, force_trig;
    assign arm_rise   = arm & ~arm_q;
    assign edge0      = syncout_0 & ~sync1_q;
    assign edge1      = syncout_1 & ~syncout_0;
    assign sync_trig  = trig_sel & (edge0 | edge1);
    assign force_trig = sw_trig | ~trig_sel;

    // State, counters, edge history and registered flags.
    always_ff @(posedge adc_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state     <= S_IDLE;
            dly_cnt   <= '0;
            waddr     <= '0;
            arm_q     <= 1'b0;
            sync1_q   <= 1'b0;
            word_q    <= '0;
            rd_ok     <= 1'b0;
            armed     <= 1'b0;
            capturing <= 1'b0;
            done      <= 1'b0;
            trig_lane <= 1'b0;
        end else begin
            state     <= state_n;
            dly_cnt   <= dly_n;
            waddr     <= waddr_n;
            arm_q     <= arm;
            sync1_q   <= syncout_1;
            word_q    <= word_c;
            rd_ok     <= 1'b1;
            armed     <= (state_n == S_ARMED);
            capturing <= (state_n == S_DELAY) || (state_n == S_CAPTURE);
            done      <= (state_n == S_DONE);
            trig_lane <= lane_n;
        end
    end

    // word_q holds the trigger-cycle word, so the first CAPTURE cycle writes it at address 0.
    always_comb begin
        state_n = state;
        dly_n   = dly_cnt;
        waddr_n = waddr;
        lane_n  = trig_lane;
        we_c    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (arm_rise) begin
                    state_n = S_ARMED;
                    waddr_n = '0;
                end
            end
            S_ARMED: begin
                if (force_trig || sync_trig) begin
                    lane_n = force_trig ? 1'b0 : ~edge0;
                    if (trig_delay == DLY_W'(0)) begin
                        state_n = S_CAPTURE;
                    end else begin
                        state_n = S_DELAY;
                        dly_n   = trig_delay;
                    end
                end
            end
            S_DELAY: begin
                if (dly_cnt == DLY_W'(1)) begin
                    state_n = S_CAPTURE;
                end else begin
                    dly_n = dly_cnt - DLY_W'(1);
                end
            end
            S_CAPTURE: begin
                we_c    = 1'b1;
                waddr_n = waddr + ADDR_W'(1);
                if (waddr == '1) begin
                    state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    ads5404_snap_ram #(
        .W      (W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (adc_clk),
        .we    (we_c),
        .waddr (waddr),
        .wdata (word_q),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    // The buffer has no reset; readout is held at zero until the first post-reset read.
    assign rd_data = rd_ok ? ram_q : '0;

endmodule

// File: tb/tb_ads5404_snapshot.sv
// Directed scoreboard bench for ads5404_snapshot: capture runs, then buffer readout checks.
module tb_ads5404_snapshot;
    import ads5404_snap_pkg::*;

    localparam int unsigned NB = 12;
    localparam int unsigned AW = 10;
    localparam int unsigned W  = word_w(NB);
`ifdef ADS5404_SNAP_OVR_EN
    localparam int OVR_AT = 8;
`else
    localparam int OVR_AT = -1;
`endif

    logic          adc_clk = 1'b0;
    logic          user_rst_n;
    logic [NB-1:0] da_0, da_1, db_0, db_1;
    logic          syncout_0, syncout_1;
    logic          ovra_0, ovra_1, ovrb_0, ovrb_1;
    logic          arm, trig_sel, sw_trig;
    logic [15:0]   trig_delay;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          armed, capturing, done, trig_lane;

    int checks = 0;
    int errors = 0;
    int cnt    = 0;

    typedef struct {
        int           addr;
        logic [W-1:0] exp;
    } rd_item_t;
    rd_item_t sb[$];
    logic     rd_req = 1'b0;
    logic     req_cap = 1'b0;
    int       req_addr_q = 0;

    always #5 adc_clk = ~adc_clk;

    ads5404_snapshot #(.NBITS(NB), .ADDR_W(AW)) dut (
        .adc_clk    (adc_clk),
        .user_rst_n (user_rst_n),
        .da_0       (da_0),
        .da_1       (da_1),
        .db_0       (db_0),
        .db_1       (db_1),
        .syncout_0  (syncout_0),
        .syncout_1  (syncout_1),
        .ovra_0     (ovra_0),
        .ovra_1     (ovra_1),
        .ovrb_0     (ovrb_0),
        .ovrb_1     (ovrb_1),
        .arm        (arm),
        .trig_sel   (trig_sel),
        .sw_trig    (sw_trig),
        .trig_delay (trig_delay),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .armed      (armed),
        .capturing  (capturing),
        .done       (done),
        .trig_lane  (trig_lane)
    );

    function automatic logic [W-1:0] exp_word(input int v, input bit ovr);
        logic [NB-1:0] a;
        a = NB'(v);
`ifdef ADS5404_SNAP_OVR_EN
        return {ovr, 3'b000, NB'(a + NB'(7)), a ^ 12'h5A5, ~a, a};
`else
        return {NB'(a + NB'(7)), a ^ 12'h5A5, ~a, a};
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_words();
        da_0 = NB'(cnt);
        da_1 = ~NB'(cnt);
        db_0 = NB'(cnt) ^ 12'h5A5;
        db_1 = NB'(cnt + 7);
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge adc_clk);
        #1;
        cnt = (cnt + 1) % 4096;
        drive_words();
    endtask

    task automatic rd(input int a, input logic [W-1:0] e);
        rd_item_t it;
        it.addr = a;
        it.exp  = e;
        sb.push_back(it);
        rd_addr = AW'(a);
        rd_req  = 1'b1;
        step();
        rd_req  = 1'b0;
    endtask

    // Monitor: a read request seen at an edge yields rd_data by the following negedge.
    always @(posedge adc_clk) begin
        req_cap    <= rd_req;
        req_addr_q <= int'(rd_addr);
    end

    always @(negedge adc_clk) begin
        if (req_cap) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: addr %0d got %0h expected none", req_addr_q, rd_data);
            end else begin
                rd_item_t it;
                it = sb.pop_front();
                if (rd_data !== it.exp) begin
                    errors++;
                    $display("FAIL rd_data[%0d]: got %0h expected %0h", it.addr, rd_data, it.exp);
                end
            end
        end
    end

    // Arm at word 0, then run until done (or abort after abort_at capturing cycles).
    task automatic run_capture(input string tag, input int sel, input int dly,
                               input int sync_at, input int sync_lane, input int sw_at,
                               input int ovr_at, input int rearm_at, input int abort_at,
                               input int exp_cycles);
        int  n;
        bit  finished;
        n        = 0;
        finished = 1'b0;
        trig_sel   = sel[0];
        trig_delay = 16'(dly);
        cnt = 0;
        drive_words();
        arm = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            step();
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (capturing) n++;
            if (abort_at >= 0 && n == abort_at) break;
            arm       = (rearm_at >= 0 && n == rearm_at);
            syncout_0 = (sync_lane == 0) && (cnt == sync_at);
            syncout_1 = (sync_lane == 1) && (cnt == sync_at);
            sw_trig   = (cnt == sw_at);
            ovrb_1    = (cnt == ovr_at);
        end
        arm = 1'b0; syncout_0 = 1'b0; syncout_1 = 1'b0; sw_trig = 1'b0; ovrb_1 = 1'b0;
        if (abort_at < 0) begin
            chk({tag, "_done"}, 64'(finished), 64'd1);
            chk({tag, "_cap_cycles"}, 64'(n), 64'(exp_cycles));
            chk({tag, "_flags_at_done"}, {62'd0, armed, capturing}, 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        user_rst_n = 1'b0;
        syncout_0 = 1'b0; syncout_1 = 1'b0;
        ovra_0 = 1'b0; ovra_1 = 1'b0; ovrb_0 = 1'b0; ovrb_1 = 1'b0;
        arm = 1'b0; trig_sel = 1'b0; sw_trig = 1'b0; trig_delay = 16'd0;
        rd_addr = '0;
        drive_words();
        step(); step();
        chk("reset_flags", {60'd0, armed, capturing, done, trig_lane}, 64'd0);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        user_rst_n = 1'b1;
        step();

        // Immediate trigger: the first ARMED cycle's word (1) lands at address 0.
        run_capture("imm", 0, 0, -1, 0, -1, OVR_AT, -1, -1, 1024);
        for (int a = 0; a < 1024; a++) rd(a, exp_word(1 + a, (1 + a) == OVR_AT));

        // syncout trigger on lane 0, word 100.
        run_capture("sync0", 1, 0, 100, 0, -1, -1, -1, -1, 1024);
        chk("sync0_lane", 64'(trig_lane), 64'd0);
        rd(0, exp_word(100, 1'b0)); rd(1, exp_word(101, 1'b0)); rd(1023, exp_word(1123, 1'b0));

        // Software trigger at word 50 with a 5-cycle delay.
        run_capture("swdly", 1, 5, -1, 0, 50, -1, -1, -1, 1029);
        chk("swdly_lane", 64'(trig_lane), 64'd0);
        rd(0, exp_word(55, 1'b0)); rd(7, exp_word(62, 1'b0)); rd(1023, exp_word(1078, 1'b0));

        // syncout trigger on lane 1, word 100.
        run_capture("sync1", 1, 0, 100, 1, -1, -1, -1, -1, 1024);
        chk("sync1_lane", 64'(trig_lane), 64'd1);
        rd(0, exp_word(100, 1'b0)); rd(512, exp_word(612, 1'b0));

        // Reset mid-capture, arm held high through reset release.
        run_capture("abort", 0, 0, -1, 0, -1, -1, -1, 300, 0);
        chk("abort_capturing_before", 64'(capturing), 64'd1);
        user_rst_n = 1'b0;
        #1;
        chk("abort_flags", {60'd0, armed, capturing, done, trig_lane}, 64'd0);
        chk("abort_rd_data", 64'(rd_data), 64'd0);
        arm = 1'b1;
        step(); step();
        user_rst_n = 1'b1;
        run_capture("rearm_rst", 0, 0, -1, 0, -1, -1, -1, -1, 1024);
        rd(0, exp_word(1, 1'b0)); rd(299, exp_word(300, 1'b0)); rd(300, exp_word(301, 1'b0));

        // Arm edge during CAPTURE is ignored; arm edge in DONE restarts.
        run_capture("arm_in_cap", 0, 0, -1, 0, -1, -1, 500, -1, 1024);
        arm = 1'b1;
        step();
        chk("rearm_done_armed", 64'(armed), 64'd1);
        chk("rearm_done_done", 64'(done), 64'd0);
        arm = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) step();
        chk("rearm_done_complete", 64'(done), 64'd1);

        step(); step(); step();
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ads5404_snapshot.md
ADS5404_SNAPSHOT -- requirements
Module: ads5404_snapshot

Interface
REQ-001 Parameter NBITS, default 12: bits per ADC sample.
REQ-002 Parameter ADDR_W, default 10: buffer depth is 2^ADDR_W words.
REQ-003 Word width W = 4*NBITS, plus 4 when ADS5404_SNAP_OVR_EN is defined.
REQ-004 adc_clk  in  1  user-side ADC clock; all logic is on this clock.
REQ-005 user_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 da_0, da_1, db_0, db_1  in  NBITS each  de-interleaved samples from the front end.
REQ-007 syncout_0, syncout_1  in  1 each  ADC sync, one bit per DDR phase.
REQ-008 ovra_0, ovra_1, ovrb_0, ovrb_1  in  1 each  overrange flags, one per DDR phase.
REQ-009 arm  in  1  level; a rising edge requests capture.
REQ-010 trig_sel  in  1  0 = trigger immediately after arm; 1 = trigger on a syncout rising edge.
REQ-011 sw_trig  in  1  pulse; forces a trigger while armed.
REQ-012 trig_delay  in  16  cycles from trigger to the first stored word.
REQ-013 rd_addr  in  ADDR_W  readout address.
REQ-014 rd_data  out  W  readout data; format {[ovr bits,] db_1, db_0, da_1, da_0}, da_0 in the LSBs.
REQ-015 armed, capturing, done  out  1 each  state flags.
REQ-016 trig_lane  out  1  DDR phase in which the syncout trigger was detected.

Function
REQ-017 FSM states are IDLE, ARMED, DELAY, CAPTURE and DONE.
REQ-018 IDLE or DONE to ARMED on an arm rising edge; done clears and the write address resets to 0.
REQ-019 An arm edge in ARMED, DELAY or CAPTURE shall be ignored.
REQ-020 ARMED fires a trigger when: trig_sel=0 (next cycle), sw_trig=1, or trig_sel=1 with a syncout rising edge.
REQ-021 Syncout edge detection:
  - Lane 0 edge = syncout_0 & ~syncout_1 of the previous cycle.
  - Lane 1 edge = syncout_1 & ~syncout_0.
  - Lane 0 has priority; trig_lane latches the winning lane; sw_trig and trig_sel=0 latch trig_lane=0.
REQ-022 On trigger with trig_delay=0, go to CAPTURE; the input word present on the trigger cycle is stored at address 0.
REQ-023 On trigger with trig_delay=N>0, go to DELAY for N cycles; the word present N cycles after the trigger is stored at address 0.
REQ-024 CAPTURE writes one word per cycle at consecutive addresses; after address 2^ADDR_W-1 is written, go to DONE (no wrap).
REQ-025 Input samples shall be pipelined internally as needed so that REQ-022 and REQ-023 hold exactly.
REQ-026 Output flags:
  - armed=1 in ARMED only.
  - capturing=1 in DELAY and CAPTURE.
  - done=1 in DONE only.
REQ-027 rd_data is registered with 1-cycle latency and is valid in any state.
REQ-028 A simultaneous read and write to the same address shall return the old data (read-first).
REQ-029 sw_trig outside ARMED shall be ignored; arm and sw_trig rising together count as arm only.

Reset
REQ-030 user_rst_n low forces IDLE; armed, capturing, done, trig_lane and rd_data are 0; counters and edge registers are cleared.
REQ-031 Reset mid-capture aborts the capture with done=0; buffer contents are not cleared.
REQ-032 The arm edge detector resets to 0, so arm held high through reset release counts as an edge.

Configuration
REQ-033 Macro ADS5404_SNAP_OVR_EN.
REQ-034 When defined: {ovrb_1, ovrb_0, ovra_1, ovra_0} are stored as the top 4 bits of each word, and W = 4*NBITS+4.
REQ-035 When undefined: overrange inputs are unused and W = 4*NBITS.

Structure
REQ-036 Package ads5404_snap_pkg holds the FSM state enum, the default NBITS and ADDR_W, and a word-width function keyed on the macro.
REQ-037 Sub-module ads5404_snap_ram: simple dual-port, read-first, registered-read RAM, W x 2^ADDR_W, no reset.

Verification
REQ-038 trig_sel=0, trig_delay=0, ramp on da_0 (0,1,2...) starting at the arm edge; after the done edge, read addresses 0..1023 -> da_0 is consecutive, offset fixed per REQ-022, done=1 after exactly 1024 capture cycles.
REQ-039 trig_sel=1, syncout_1 pulse with syncout_0=0 at input word value 100 -> address 0 holds 100, trig_lane=1; same test on syncout_0 -> trig_lane=0.
REQ-040 trig_delay=5, sw_trig at word K -> address 0 holds word K+5; capturing=1 for 5+1024 cycles.
REQ-041 Assert user_rst_n low at capture address 300 -> IDLE, all flags 0; a re-arm then completes a full capture.
REQ-042 Re-arm during CAPTURE -> ignored, done asserts on schedule; re-arm in DONE -> done clears, armed=1.
REQ-043 With ADS5404_SNAP_OVR_EN, ovrb_1=1 at address 7 only -> rd_data[W-1]=1 at address 7 and 0 elsewhere; without the macro, W=48.
